// File: rtl/uart_pkg.sv
// Shared types and constants for the UART datapath.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_115200 = 280;
    localparam int unsigned UART_DATA_W         = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
    parameter bit RstVal = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; both stages come out of reset at RstVal.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RstVal;
            r_sync <= RstVal;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned ClksPerBit = CLKS_PER_BIT_115200
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   frame_err_o,
    output logic                   overrun_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    // Thresholds are one less than the interval because a state entered
    // with a cleared counter sees count 0 on its first decision edge.
    localparam logic [CntW-1:0] HalfM1 = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(ClksPerBit - 1);
    localparam logic [2:0]      LastBit = 3'(UART_DATA_W - 1);

    logic                   w_rx_s;
    logic                   r_rx_q;

    rx_state_e              r_state;
    rx_state_e              w_state_nxt;
    logic [CntW-1:0]        r_cnt;
    logic [CntW-1:0]        w_cnt_nxt;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_bit_idx_nxt;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_nxt;
    logic                   w_deliver;
    logic                   w_ferr;
    logic                   r_deliver;
    logic                   r_ferr;

    logic [UART_DATA_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    sync_2ff #(
        .RstVal (1'b1)
    ) u_sync_rx (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_d     (rx_i),
        .o_q     (w_rx_s)
    );

    // Delayed copy of the synchronized line for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_q <= 1'b1;
        end else begin
            r_rx_q <= w_rx_s;
        end
    end

    // Frame FSM state, bit timing and shift register; strobes registered once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_deliver <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_deliver <= w_deliver;
            r_ferr    <= w_ferr;
        end
    end

    // Next-state logic: mid-bit sampling of start, data and stop bits.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CntW'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_deliver     = 1'b0;
        w_ferr        = 1'b0;
        unique case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                if (r_rx_q && !w_rx_s) begin
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == HalfM1) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_state_nxt   = RX_DATA;
                        w_bit_idx_nxt = '0;
                    end
                end
            end
            RX_DATA: begin
                if (r_cnt == FullM1) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == LastBit) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt == FullM1) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    // Holding register: load on delivery, drop and flag when still occupied.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= r_ferr;
            r_overrun   <= 1'b0;
            if (r_deliver) begin
                if (!r_valid || ready_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at the default 280 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 280;
    localparam int VALID_LAT = 2663;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int rise_cyc = -1;
    int n_vrise = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_unstable = 0;
    logic [7:0] q_acc[$];
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    uart_rx #(
        .ClksPerBit (CPB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    // Cycle counter: after active edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid_o && !pv) begin
            rise_cyc = cyc;
            n_vrise++;
        end
        if (valid_o && ready_i) q_acc.push_back(data_o);
        if (frame_err_o) n_ferr++;
        if (overrun_o) n_ovr++;
        if (pv && !pr && valid_o && (data_o != pd)) n_unstable++;
        pv = valid_o;
        pr = ready_i;
        pd = data_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives one full frame; caller is at posedge+2, returns at posedge+2.
    task automatic send_frame(input logic [7:0] b, input logic stop_b, output int t0);
        t0 = cyc + 1;
        rx_i = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            cycles(CPB);
        end
        rx_i = stop_b;
        cycles(CPB);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        if (q_acc.size() == 0) check(tag, 32'hDEAD, {24'h0, exp});
        else check(tag, {24'h0, q_acc.pop_front()}, {24'h0, exp});
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (!valid_o && k < budget) begin
            cycles(1);
            k++;
        end
        check(tag, {31'h0, valid_o}, 32'h1);
    endtask

    task automatic pulse_ready();
        ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
    endtask

    initial begin
        int t0;
        int t_dummy;
        int vr0;
        int fe0;
        int ov0;
        logic [7:0] exp_b2 [2];
        exp_b2[0] = 8'h00;
        exp_b2[1] = 8'hFF;

        rst_n = 1'b0;
        rx_i = 1'b1;
        ready_i = 1'b0;
        cycles(3);
        check("reset data_o", {24'h0, data_o}, 32'h0);
        check("reset valid_o", {31'h0, valid_o}, 32'h0);
        check("reset frame_err_o", {31'h0, frame_err_o}, 32'h0);
        check("reset overrun_o", {31'h0, overrun_o}, 32'h0);
        rst_n = 1'b1;
        cycles(10);

        // Single byte with consumer always ready.
        ready_i = 1'b1;
        vr0 = n_vrise;
        send_frame(8'h41, 1'b1, t0);
        check("t1 valid rise cycle", 32'(rise_cyc), 32'(t0 + VALID_LAT));
        check("t1 one valid", 32'(n_vrise - vr0), 32'd1);
        expect_byte("t1 byte 0x41", 8'h41);
        check("t1 valid one cycle", {31'h0, valid_o}, 32'h0);
        check("t1 no frame_err", 32'(n_ferr), 32'd0);
        check("t1 no overrun", 32'(n_ovr), 32'd0);
        ready_i = 1'b0;
        cycles(20);

        // Back-to-back frames, consumer pulses ready after each byte.
        fork
            begin
                send_frame(8'h00, 1'b1, t_dummy);
                send_frame(8'hFF, 1'b1, t_dummy);
            end
            begin
                for (int i = 0; i < 2; i++) begin
                    wait_valid("t2 wait valid", 6000);
                    cycles(20);
                    check("t2 held data", {24'h0, data_o}, {24'h0, exp_b2[i]});
                    pulse_ready();
                end
            end
        join
        expect_byte("t2 first 0x00", 8'h00);
        expect_byte("t2 second 0xFF", 8'hFF);
        check("t2 no overrun", 32'(n_ovr), 32'd0);
        check("t2 data stable", 32'(n_unstable), 32'd0);
        cycles(20);

        // Short low glitch, then a real frame.
        vr0 = n_vrise;
        rx_i = 1'b0;
        cycles(100);
        rx_i = 1'b1;
        cycles(300);
        check("t3 no valid on glitch", 32'(n_vrise - vr0), 32'd0);
        check("t3 fsm idle", 32'(dut.r_state), 32'(RX_IDLE));
        ready_i = 1'b1;
        send_frame(8'h5A, 1'b1, t0);
        expect_byte("t3 byte 0x5A", 8'h5A);
        ready_i = 1'b0;
        cycles(20);

        // Bad stop bit with the line held low afterwards.
        vr0 = n_vrise;
        fe0 = n_ferr;
        send_frame(8'h55, 1'b0, t0);
        cycles(1000);
        rx_i = 1'b1;
        cycles(300);
        check("t4 one frame_err", 32'(n_ferr - fe0), 32'd1);
        check("t4 no valid", 32'(n_vrise - vr0), 32'd0);
        ready_i = 1'b1;
        send_frame(8'h33, 1'b1, t0);
        expect_byte("t4 byte 0x33", 8'h33);
        ready_i = 1'b0;
        cycles(20);

        // Second byte while the first is unconsumed.
        ov0 = n_ovr;
        send_frame(8'h11, 1'b1, t0);
        send_frame(8'h22, 1'b1, t0);
        cycles(20);
        check("t5 one overrun", 32'(n_ovr - ov0), 32'd1);
        check("t5 data kept", {24'h0, data_o}, 32'h11);
        check("t5 valid kept", {31'h0, valid_o}, 32'h1);
        check("t5 data stable", 32'(n_unstable), 32'd0);
        pulse_ready();
        cycles(2);
        expect_byte("t5 accepted 0x11", 8'h11);
        check("t5 valid cleared", {31'h0, valid_o}, 32'h0);
        cycles(20);

        // Reset during data bit 4 of 0xA5; the sender aborts with the reset.
        vr0 = n_vrise;
        rx_i = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_i = (8'hA5 >> i) & 8'h01;
            cycles(CPB);
        end
        rx_i = 1'b0;
        cycles(150);
        check("t6 mid-frame state", 32'(dut.r_state), 32'(RX_DATA));
        rst_n = 1'b0;
        rx_i = 1'b1;
        cycles(1);
        check("t6 rst data_o", {24'h0, data_o}, 32'h0);
        check("t6 rst valid_o", {31'h0, valid_o}, 32'h0);
        check("t6 rst frame_err_o", {31'h0, frame_err_o}, 32'h0);
        check("t6 rst overrun_o", {31'h0, overrun_o}, 32'h0);
        check("t6 rst fsm idle", 32'(dut.r_state), 32'(RX_IDLE));
        cycles(9);
        rst_n = 1'b1;
        cycles(300);
        check("t6 no spurious byte", 32'(n_vrise - vr0), 32'd0);
        ready_i = 1'b1;
        send_frame(8'h3C, 1'b1, t0);
        check("t6 valid rise cycle", 32'(rise_cyc), 32'(t0 + VALID_LAT));
        expect_byte("t6 byte 0x3C", 8'h3C);
        check("t6 one valid", 32'(n_vrise - vr0), 32'd1);
        check("t6 queue empty", 32'(q_acc.size()), 32'd0);
        ready_i = 1'b0;
        cycles(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
# uart_rx

UART receiver for the ALU/UART datapath. It converts the serial `rx_i` line (8N1, LSB first, idle high) into bytes on a valid/ready interface. The byte stream feeds the command/echo logic that drives `tx_o`. It runs on the 32.256 MHz board clock, where 280 clocks make one bit at 115200 baud.

## Interface
- `ClksPerBit`, default 280: clocks per bit period. Must be at least 4.
- `clk_i`  input  1  system clock. One clock domain.
- `rst_ni`  input  1  reset, asynchronous assert, active-low.
- `rx_i`  input  1  asynchronous serial line, idle high.
- `data_o`  output  8  received byte. Reset value 0x00.
- `valid_o`  output  1  `data_o` holds an unconsumed byte. Reset value 0.
- `ready_i`  input  1  consumer accepts the byte when `valid_o && ready_i`.
- `frame_err_o`  output  1  one-cycle pulse: the stop bit sampled 0. Reset value 0.
- `overrun_o`  output  1  one-cycle pulse: a byte was dropped because the holding register was full. Reset value 0.

## Operation
- `rx_i` passes through a 2-FF synchronizer (flops reset to 1), producing `rx_s`. A third flop `rx_q` delays `rx_s` for edge detection.
- Bit counter width is `$clog2(ClksPerBit)`. Bit index is 3 bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: on `rx_q==1 && rx_s==0`, clear the counter and go to START.
  - START: at count `ClksPerBit/2` (integer divide), sample `rx_s`.
    - If 1, it was a glitch: go to IDLE.
    - If 0, clear the counter and go to DATA.
  - DATA: every `ClksPerBit` clocks, sample `rx_s` into the shift register at the current bit index (LSB first). After bit 7, go to STOP.
  - STOP: after `ClksPerBit` clocks, sample `rx_s`.
    - If 1, deliver the byte and go to IDLE. Returning at mid-stop allows back-to-back frames.
    - If 0, pulse `frame_err_o`, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. A held-low line yields exactly one `frame_err_o`.
- Holding register rules:
  - Delivery with `valid_o==0`: load `data_o` and set `valid_o`.
  - Delivery with `valid_o==1 && ready_i==1` in the same cycle: load the new byte, keep `valid_o` high, no overrun.
  - Delivery with `valid_o==1 && ready_i==0`: keep the old byte and pulse `overrun_o`.
  - `valid_o && ready_i` with no delivery: clear `valid_o`. `data_o` keeps its value.
- `data_o` is stable while `valid_o` is high and `ready_i` is low.
- A `rst_ni` assertion at any point, including mid-frame, immediately returns every flop to its reset value: FSM to IDLE, synchronizer flops to 1, outputs as listed above. After release, a frame already in progress is not recovered. The receiver waits for the next falling edge.

## Timing
- T is the first clock edge at which `rx_i`=0 is sampled. `rx_s` falls at T+2, so the edge is detected at cycle E = T+2.
- Start-bit sample: E + `ClksPerBit/2`.
- Data bit k sample: E + `ClksPerBit/2` + (k+1)·`ClksPerBit`.
- Stop-bit sample: E + `ClksPerBit/2` + 9·`ClksPerBit`.
- `valid_o`, `frame_err_o` and `overrun_o` are registered and change one cycle after the stop sample. With the default 280, `valid_o` rises at T+2663.
- All outputs are registered. There is no combinational path from `ready_i` or `rx_i` to any output.
- Sampling at mid-bit tolerates roughly ±4% baud mismatch.

## Structure
- Package `uart_pkg`:
  - `rx_state_e` enum holding the five states.
  - `CLKS_PER_BIT_115200 = 280`.
  - `UART_DATA_W = 8`.
- Sub-module `sync_2ff`: a generic 1-bit two-flop synchronizer with a reset-value parameter. It is reused later on other asynchronous inputs.

## Test plan
- Send 0x41 with `ready_i`=1 → `data_o`=0x41 and `valid_o` high for one cycle at T+2663. No error pulses.
- Send 0x00 then 0xFF back-to-back (stop bit 280 clocks, no idle gap) with `ready_i`=0, pulsing `ready_i` after each byte → both bytes delivered in order. `data_o` is held until each handshake.
- Drive `rx_i` low for 100 clocks, then high → no `valid_o`, FSM back in IDLE. A following 0x5A is received correctly.
- Send 0x55 with the stop bit driven 0 and the line then held low for 1000 clocks → exactly one `frame_err_o` pulse, no `valid_o`. Once the line rises, the next 0x33 is received correctly.
- Send 0x11 then 0x22 with `ready_i`=0 throughout → one `overrun_o` pulse at the second byte. `data_o` stays 0x11 with `valid_o` high.
- Assert `rst_ni` during data bit 4 of 0xA5, release after 10 clocks, then send 0x3C → all outputs at reset values during reset, no spurious byte, and 0x3C received.
